// File: rtl/i2c_fsm_burst.sv
// Control FSM for the myfilter I2C slave: address phase, multi-byte write and
// read bursts, write overflow NACK, master-ACK handling and SCL stretching.
module i2c_fsm_burst #(
  parameter int N_BYTES    = 4,
  parameter bit STRETCH_EN = 1'b1,
  parameter int CNT_W      = $clog2(N_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             scl_rise_in,
  input  logic             scl_fall_in,
  input  logic             sda_in,
  input  logic             addrok_in,
  input  logic             rw_in,
  input  logic             rdy_in,
  output logic             sde_out,
  output logic             clr_out,
  output logic             dl_out,
  output logic             ul_out,
  output logic             next_out,
  output logic             ack_out,
  output logic             oe_out,
  output logic             osel_out,
  output logic             stretch_out,
  output logic             ovf_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] byte_idx_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_WAIT, S_WR_ACK,
    S_WR_NACK, S_RD_WAIT, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             mack_q, mack_d;
  logic             go;
  logic [CNT_W-1:0] byte_inc;

  // With stretching disabled the datapath is assumed always ready.
  assign go       = rdy_in | ~STRETCH_EN;
  assign byte_inc = (byte_cnt_q == CNT_W'(N_BYTES)) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      mack_q     <= mack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    mack_d      = mack_q;
    sde_out     = 1'b0;
    clr_out     = 1'b0;
    dl_out      = 1'b0;
    ul_out      = 1'b0;
    next_out    = 1'b0;
    ack_out     = 1'b0;
    oe_out      = 1'b0;
    osel_out    = 1'b0;
    stretch_out = 1'b0;
    ovf_out     = 1'b0;

    if (start_in) begin
      state_d    = S_ADDR;
      clr_out    = 1'b1;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      mack_d     = 1'b0;
    end else if (stop_in) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: ;
        S_ADDR, S_WR_DATA: begin
          if (scl_rise_in && bit_cnt_q < 4'd8) begin
            sde_out   = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_in && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (state_q == S_ADDR) begin
              state_d = addrok_in ? S_ADDR_ACK : S_IGNORE;
            end else if (byte_cnt_q < CNT_W'(N_BYTES)) begin
              state_d = S_WR_WAIT;
            end else begin
              state_d = S_WR_NACK;
              ovf_out = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          oe_out  = 1'b1;
          ack_out = 1'b1;
          if (scl_fall_in) begin
            if (rw_in) begin
              state_d = S_RD_WAIT;
            end else begin
              state_d = S_WR_DATA;
              clr_out = 1'b1;
            end
          end
        end
        S_WR_WAIT: begin
          if (go) begin
            dl_out  = 1'b1;
            state_d = S_WR_ACK;
          end else begin
            stretch_out = 1'b1;
          end
        end
        S_WR_ACK: begin
          oe_out  = 1'b1;
          ack_out = 1'b1;
          if (scl_fall_in) begin
            next_out   = 1'b1;
            clr_out    = 1'b1;
            byte_cnt_d = byte_inc;
            state_d    = S_WR_DATA;
          end
        end
        S_WR_NACK: begin
          if (scl_fall_in) state_d = S_IGNORE;
        end
        S_RD_WAIT: begin
          if (go) begin
            ul_out  = 1'b1;
            state_d = S_RD_DATA;
          end else begin
            stretch_out = 1'b1;
          end
        end
        S_RD_DATA: begin
          oe_out   = 1'b1;
          osel_out = 1'b1;
          // The first bit is already on SDA after the load, so only 7 shifts.
          if (scl_fall_in) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = S_RD_ACK;
            end else begin
              sde_out   = 1'b1;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise_in) mack_d = sda_in;
          if (scl_fall_in) begin
            if (!mack_q) begin
              next_out   = 1'b1;
              byte_cnt_d = byte_inc;
              state_d    = S_RD_WAIT;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_out     = (state_q != S_IDLE) && (state_q != S_IGNORE);
  assign byte_idx_out = byte_cnt_q;

endmodule

// File: doc/i2c_fsm_burst.md
Name: i2c_fsm_burst

Overview:
Parametrised control FSM for the myfilter I2C slave, the successor to the single-frame i2c_fsm. It sequences the external shift-register/register-bank datapath through address, multi-byte write and multi-byte read bursts. It adds an internal bit counter, a byte counter with overflow NACK, read-burst master-ACK handling and optional SCL clock stretching while the datapath is not ready. It sits between the SCL/SDA edge detectors and the I2C datapath.

Parameters:
N_BYTES, 4, maximum data bytes accepted per write burst; byte N_BYTES+1 is NACKed
STRETCH_EN, 1, 1 = hold SCL low while rdy_in=0 before dl/ul; 0 = never stretch, pulse dl/ul unconditionally
CNT_W, $clog2(N_BYTES+1), byte counter width (derived, do not override)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_in  input  1  START/repeated-START detected (1-cycle pulse)
stop_in  input  1  STOP detected (1-cycle pulse)
scl_rise_in  input  1  SCL rising edge (1-cycle pulse)
scl_fall_in  input  1  SCL falling edge (1-cycle pulse)
sda_in  input  1  synchronised SDA
addrok_in  input  1  shift register holds matching 7-bit address
rw_in  input  1  R/W bit from shift register LSB (1 = read)
rdy_in  input  1  register bank ready for dl/ul
sde_out  output  1  shift enable
clr_out  output  1  clear shift register
dl_out  output  1  write shift register to bank at pointer
ul_out  output  1  load shift register from bank at pointer
next_out  output  1  increment register pointer
ack_out  output  1  ACK phase indicator
oe_out  output  1  SDA output enable (drives low or shift MSB)
osel_out  output  1  0 = drive ACK (0), 1 = drive shift MSB
stretch_out  output  1  hold SCL low
ovf_out  output  1  write-burst overflow (1-cycle pulse)
busy_out  output  1  transaction addressed to this slave in progress
byte_idx_out  output  CNT_W  bytes completed in current burst, saturates at N_BYTES

Behaviour:
- Reset (async, rst_n=0): state IDLE, bit/byte counters 0, all outputs 0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_WAIT, WR_ACK, WR_NACK, RD_WAIT, RD_DATA, RD_ACK, IGNORE.
- Global priority: start_in → ADDR from any state, with clr_out=1 that cycle and counters cleared. Else stop_in → IDLE. start and stop in the same cycle: start wins.
- Outputs: Mealy pulses are combinational on the qualifying strobe. Level outputs are decoded from the state.
- ADDR and WR_DATA: sde_out=scl_rise_in; bit counter increments on each rise. On the first scl_fall after the 8th rise, the bit counter clears and:
  - ADDR: addrok_in=1 → ADDR_ACK; else → IGNORE.
  - WR_DATA: byte_cnt<N_BYTES → WR_WAIT; else → WR_NACK with ovf_out=1.
- ADDR_ACK, WR_ACK: oe_out=1, osel_out=0, ack_out=1, held until scl_fall.
  - ADDR_ACK exit: rw_in=0 → WR_DATA with clr_out=1; rw_in=1 → RD_WAIT.
  - WR_ACK exit: next_out=1, clr_out=1, byte_cnt+1 → WR_DATA.
- WR_WAIT: rdy_in=1 (or STRETCH_EN=0) → dl_out=1 for one cycle, → WR_ACK. Otherwise stretch_out=1, remain.
- WR_NACK: oe_out=0 for the ACK bit, no dl_out; on scl_fall → IGNORE.
- RD_WAIT: rdy_in=1 (or STRETCH_EN=0) → ul_out=1 for one cycle, → RD_DATA. Otherwise stretch_out=1.
- RD_DATA: oe_out=1, osel_out=1. Falls 1..7 give sde_out=1; fall 8 gives no shift, → RD_ACK.
- RD_ACK: oe_out=0. Master ACK flag is latched from sda_in on scl_rise. On scl_fall:
  - flag=0 (ACK): next_out=1, byte_cnt+1 (saturating), → RD_WAIT.
  - flag=1 (NACK): → IGNORE.
  - Read bursts never overflow; the pointer wrap belongs to the datapath.
- IGNORE: all outputs 0 until start/stop.
- busy_out=1 in every state except IDLE and IGNORE. byte_idx_out=byte_cnt.
- stretch_out is released on the same cycle dl_out/ul_out pulse. stretch_out is never asserted in any other state.
- Spurious scl edges in IDLE/IGNORE are ignored.
- START or STOP mid-byte aborts without a dl_out/ul_out/next_out pulse.

Test Plan:
- Write burst: START, addr 0x50+W (addrok=1), 3 bytes, rdy_in=1, STOP → three dl_out pulses, three next_out pulses, 8 sde_out per byte, byte_idx_out=3, ACK driven 4 times.
- Overflow: N_BYTES=4, write 5 bytes → 4 dl_out, ovf_out=1 at the 5th byte end, oe_out=0 during the 5th ACK bit, state IGNORE until STOP.
- Read burst: addr+R, master ACKs bytes 1–2, NACKs byte 3 → 3 ul_out, 7 sde_out per byte, 2 next_out, IGNORE after byte 3.
- Stretch: STRETCH_EN=1, rdy_in=0 for 10 cycles at the write-byte end → stretch_out=1 for 10 cycles, dl_out=1 on the cycle rdy_in rises. With STRETCH_EN=0 → dl_out immediately, stretch_out stays 0.
- Address mismatch plus repeated START: addrok_in=0 → no ACK, IGNORE. Then start_in (same cycle as stop_in) → ADDR, clr_out=1.
- Async reset mid-WR_DATA after 4 bits → all outputs 0 immediately, IDLE after release, byte_idx_out=0.
